// File: rtl/host_step_decoder.sv
// host_step_decoder: host floppy bus STEP/DIR/SEL/SIDE front end for the
// emulated drive. Synchronizes the bus pins, qualifies step pulses by their
// low width, tracks the head position with clamping at both end stops, and
// times the head-settle period after every accepted step.
module host_step_decoder #(
    parameter int MAX_TRACK     = 79,
    parameter int TRACK_W       = 7,
    parameter int MIN_PULSE_CYC = 12,
    parameter int SETTLE_CYC    = 180000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_n,
    input  logic               dir_n,
    input  logic               sel_n,
    input  logic               side_n,
    output logic [TRACK_W-1:0] track,
    output logic               side,
    output logic               track_0,
    output logic               seek_busy,
    output logic               step_evt
);

    localparam int PULSE_W  = $clog2(MIN_PULSE_CYC + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

    localparam logic [PULSE_W-1:0]  PULSE_MAX   = PULSE_W'(MIN_PULSE_CYC);
    localparam logic [PULSE_W-1:0]  PULSE_ONE   = PULSE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [TRACK_W-1:0]  TRACK_MAX   = TRACK_W'(MAX_TRACK);
    localparam logic [TRACK_W-1:0]  TRACK_ONE   = TRACK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOW   = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    // Bus pins are packed as {step, dir, sel, side} through the synchronizer.
    logic [3:0]          sync1_d, sync1_q;
    logic [3:0]          sync2_d, sync2_q;
    logic                step_prev_d, step_prev_q;
    logic                side_d, side_q;
    state_t              state_d, state_q;
    logic [PULSE_W-1:0]  width_d, width_q;
    logic [TRACK_W-1:0]  track_d, track_q;
    logic                track_0_d, track_0_q;
    logic                step_evt_d, step_evt_q;
    logic [SETTLE_W-1:0] settle_d, settle_q;
    logic                busy_d, busy_q;
    logic                accept;

    logic step_s, dir_s, sel_s, side_s;

    assign step_s = sync2_q[3];
    assign dir_s  = sync2_q[2];
    assign sel_s  = sync2_q[1];
    assign side_s = sync2_q[0];

    // Two-flop synchronizer inputs, step edge history and registered side.
    always_comb begin
        sync1_d     = {step_n, dir_n, sel_n, side_n};
        sync2_d     = sync1_q;
        step_prev_d = step_s;
        side_d      = ~side_s;
    end

    // Step qualifier: a pulse must start with a falling edge while selected,
    // so a pulse that began deselected can never be picked up halfway through.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        accept  = 1'b0;
        if (sel_s) begin
            state_d = S_IDLE;
            width_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!step_s && step_prev_q) begin
                        width_d = PULSE_ONE;
                        state_d = (MIN_PULSE_CYC <= 1) ? S_ARMED : S_LOW;
                    end
                end
                S_LOW: begin
                    if (step_s) begin
                        state_d = S_IDLE;
                    end else begin
                        width_d = width_q + PULSE_ONE;
                        if (width_d >= PULSE_MAX) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (step_s) begin
                        accept  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Head position update on an accepted step, clamped at both end stops.
    always_comb begin
        track_d = track_q;
        if (accept) begin
            if (!dir_s) begin
                track_d = (track_q >= TRACK_MAX) ? TRACK_MAX : track_q + TRACK_ONE;
            end else begin
                track_d = (track_q == '0) ? '0 : track_q - TRACK_ONE;
            end
        end
        track_0_d  = (track_d != '0);
        step_evt_d = accept;
    end

    // Settle timer: every accepted step restarts the full settle period.
    always_comb begin
        settle_d = settle_q;
        if (accept) begin
            settle_d = SETTLE_LOAD;
        end else if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_ONE;
        end
        busy_d = accept | (settle_q != '0);
    end

    // State register; the synchronizer idles high like the undriven bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            step_prev_q <= 1'b1;
            side_q      <= 1'b0;
            state_q     <= S_IDLE;
            width_q     <= '0;
            track_q     <= '0;
            track_0_q   <= 1'b0;
            step_evt_q  <= 1'b0;
            settle_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            step_prev_q <= step_prev_d;
            side_q      <= side_d;
            state_q     <= state_d;
            width_q     <= width_d;
            track_q     <= track_d;
            track_0_q   <= track_0_d;
            step_evt_q  <= step_evt_d;
            settle_q    <= settle_d;
            busy_q      <= busy_d;
        end
    end

    assign track     = track_q;
    assign side      = side_q;
    assign track_0   = track_0_q;
    assign seek_busy = busy_q;
    assign step_evt  = step_evt_q;

endmodule

// File: doc/host_step_decoder.md
Name: host_step_decoder

Overview:
- Receives head-positioning control from the host floppy bus (STEP, DIR, DRIVE SELECT, SIDE SELECT) into the emulated drive.
- Synchronizes the inputs, qualifies step pulses, and maintains the emulated head track position with end-stop clamping.
- Drives the active-low Track 00 bus output, the side select, and a seek-settle busy flag for the track-buffer logic.

Parameters:
- MAX_TRACK, 79, highest reachable track; the track counter clamps here.
- TRACK_W, 7, width of the track output; must satisfy 2^TRACK_W > MAX_TRACK.
- MIN_PULSE_CYC, 12, minimum qualified low width of step_n in clk cycles (1 us at 12 MHz).
- SETTLE_CYC, 180000, head-settle time in clk cycles after each accepted step (15 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- step_n  in  1  bus pin 20, /STEP, active-low, asynchronous to clk.
- dir_n  in  1  bus pin 18, /DIR; low = inward (track+1), high = outward (track-1).
- sel_n  in  1  bus drive select, active-low.
- side_n  in  1  bus pin 32, /SIDE1; low = side 1.
- track  out  TRACK_W  current head track, 0..MAX_TRACK.
- side  out  1  registered head side: 1 = side 1.
- track_0  out  1  bus pin 26, active-low: 0 when track==0, 1 otherwise.
- seek_busy  out  1  high while head settle is in progress.
- step_evt  out  1  one-cycle pulse on each accepted step, including clamped steps.

Behaviour:
- Reset (async, rst_n low): track=0, track_0=0 (asserted), side=0, seek_busy=0, step_evt=0, FSM=IDLE, all synchronizer flops=1 (bus idle-high).
- Synchronization: step_n, dir_n, sel_n and side_n each pass through 2 flops. All logic below uses only the synced versions.
- Side: side <= ~side_s every cycle; total latency is 3 clk from the pin. Independent of sel_n.
- FSM states: IDLE, LOW, ARMED.
  - IDLE: when step_s==0 and sel_s==0, load width counter=1 and go to LOW.
  - LOW: while step_s==0, increment the counter. Go to ARMED when counter reaches MIN_PULSE_CYC. If step_s returns to 1 before then, go to IDLE; this is a glitch and no step is taken.
  - ARMED: wait for step_s==1 (trailing edge). On that cycle, accept the step and return to IDLE.
  - Any state: sel_s==1 forces IDLE with no step. Deselect mid-pulse aborts the pulse.
- Step acceptance, trailing-edge cycle:
  - dir_s is sampled on this same cycle.
  - Inward: track <= min(track+1, MAX_TRACK). Outward: track <= track-1, or 0 if track==0; no wrap-around.
  - step_evt=1 for exactly this cycle, even when clamped at either end.
- Settle:
  - Each accepted step reloads the settle counter to SETTLE_CYC and sets seek_busy=1 on the following cycle.
  - seek_busy falls the cycle after the counter reaches 0.
  - A step accepted during settle is honoured, updates track and restarts the full settle time. Steps are never dropped for rate.
- track_0 is registered from the next value of track, so it changes in the same cycle as track.
- Step pulses that started while deselected are not counted, even if sel_n asserts during the low phase. Qualification begins only from IDLE with sel_s==0.
- Reset asserted mid-pulse or mid-settle returns to the reset state immediately. There is no resume after reset release.

Test Plan (bench uses MIN_PULSE_CYC=4, SETTLE_CYC=20, MAX_TRACK=79):
- Reset release with bus idle -> track=0, track_0=0, seek_busy=0. Then one 6-cycle step pulse, dir_n=0, sel_n=0 -> step_evt pulse, track=1, track_0=1, seek_busy high for about 20 cycles.
- Glitch rejection: step_n low for 2 cycles -> no step_evt, track unchanged. Pulse of exactly 4 cycles (synced) -> accepted.
- Clamping: at track 0, outward step -> step_evt=1, track stays 0, track_0=0. Drive to 79 with inward steps, then 3 more inward -> track=79 and 3 step_evt pulses.
- Deselect: sel_n=1 during a 6-cycle pulse, and separately sel_n rising mid-pulse -> no step_evt, track unchanged.
- Settle restart: second step accepted 10 cycles into settle -> track advances by 2, seek_busy stays high continuously until about 20 cycles after the second step.
- Async reset mid-settle at track 5 -> track=0, track_0=0, seek_busy=0 without a clock edge. side_n=0 -> side=1 after 3 clk.
